// File: rtl/hamming_pkg.sv
// Shared Hamming (7,4) definitions for the encoder/decoder link.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  // Syndrome {s2,s1,s0} value that points at each codeword bit
  localparam logic [2:0] SYN_D0 = 3'b011;
  localparam logic [2:0] SYN_D1 = 3'b101;
  localparam logic [2:0] SYN_D2 = 3'b110;
  localparam logic [2:0] SYN_D3 = 3'b111;
  localparam logic [2:0] SYN_P0 = 3'b001;
  localparam logic [2:0] SYN_P1 = 3'b010;
  localparam logic [2:0] SYN_P2 = 3'b100;

  typedef logic [0:CODE_W-1] codeword_t;
  typedef logic [0:DATA_W-1] data_t;

  // Flip the data bit named by the syndrome; parity or zero syndromes pass data through
  function automatic data_t hamming_correct(input data_t raw, input logic [2:0] syn);
    data_t fixed;
    fixed = raw;
    case (syn)
      SYN_D0:  fixed[0] = ~raw[0];
      SYN_D1:  fixed[1] = ~raw[1];
      SYN_D2:  fixed[2] = ~raw[2];
      SYN_D3:  fixed[3] = ~raw[3];
      default: fixed = raw;
    endcase
    return fixed;
  endfunction

  // Syndrome names a data bit
  function automatic logic syn_is_data(input logic [2:0] syn);
    return (syn == SYN_D0) || (syn == SYN_D1) || (syn == SYN_D2) || (syn == SYN_D3);
  endfunction

  // Syndrome names a parity bit
  function automatic logic syn_is_par(input logic [2:0] syn);
    return (syn == SYN_P0) || (syn == SYN_P1) || (syn == SYN_P2);
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational raw-data recovery and syndrome computation for one codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  codeword_t  code,
  output data_t      data,
  output logic [2:0] syn
);

  // d0 travels inverted on the link; parity checks use the recovered (true) data
  always_comb begin
    data   = {~code[0], code[1:3]};
    syn[0] = code[4] ^ data[0] ^ data[1] ^ data[3];
    syn[1] = code[5] ^ data[0] ^ data[2] ^ data[3];
    syn[2] = code[6] ^ data[1] ^ data[2] ^ data[3];
  end

endmodule

// File: rtl/decoding.sv
// Two-stage single-error-correcting Hamming decoder with per-block statistics.
module decoding
  import hamming_pkg::*;
#(
  parameter int WORDS = 7,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:6]       byte_in,
  input  logic             active,
  output logic [0:3]       bits_out,
  output logic             ready,
  output logic             err_fixed,
  output logic             par_err,
  output logic [CNT_W-1:0] err_count,
  output logic             done
);

  localparam int WC_W = $clog2(WORDS + 1);

  data_t            raw_w;
  logic [2:0]       syn_w;
  logic             accept;

  data_t            raw_q, raw_d;
  logic [2:0]       syn_q, syn_d;
  logic [1:0]       vld_pipe_q, vld_pipe_d;
  logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             done_q, done_d;
  data_t            bits_out_q, bits_out_d;
  logic             err_fixed_q, err_fixed_d;
  logic             par_err_q, par_err_d;

  hamming_syndrome u_syn (
    .code (byte_in),
    .data (raw_w),
    .syn  (syn_w)
  );

  // Once the block is full every further word is dropped until reset
  assign accept = active & ~done_q;

  // Stage 1: capture raw data/syndrome and update block statistics
  always_comb begin
    raw_d       = raw_q;
    syn_d       = syn_q;
    word_cnt_d  = word_cnt_q;
    err_count_d = err_count_q;
    done_d      = done_q;
    vld_pipe_d  = {vld_pipe_q[0], accept};
    if (accept) begin
      raw_d      = raw_w;
      syn_d      = syn_w;
      word_cnt_d = word_cnt_q + WC_W'(1);
      if ((syn_w != 3'b000) && (err_count_q != {CNT_W{1'b1}}))
        err_count_d = err_count_q + CNT_W'(1);
      if (word_cnt_q == WC_W'(WORDS - 1))
        done_d = 1'b1;
    end
  end

  // Stage 2: correct and present; outputs hold while no word is in stage 2
  always_comb begin
    bits_out_d  = bits_out_q;
    err_fixed_d = err_fixed_q;
    par_err_d   = par_err_q;
    if (vld_pipe_q[0]) begin
      bits_out_d  = hamming_correct(raw_q, syn_q);
      err_fixed_d = syn_is_data(syn_q);
      par_err_d   = syn_is_par(syn_q);
    end
  end

  // All state; reset discards in-flight words along with the statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_q       <= '0;
      syn_q       <= '0;
      vld_pipe_q  <= '0;
      word_cnt_q  <= '0;
      err_count_q <= '0;
      done_q      <= 1'b0;
      bits_out_q  <= '0;
      err_fixed_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      raw_q       <= raw_d;
      syn_q       <= syn_d;
      vld_pipe_q  <= vld_pipe_d;
      word_cnt_q  <= word_cnt_d;
      err_count_q <= err_count_d;
      done_q      <= done_d;
      bits_out_q  <= bits_out_d;
      err_fixed_q <= err_fixed_d;
      par_err_q   <= par_err_d;
    end
  end

  assign bits_out  = bits_out_q;
  assign ready     = vld_pipe_q[1];
  assign err_fixed = err_fixed_q;
  assign par_err   = par_err_q;
  assign err_count = err_count_q;
  assign done      = done_q;

endmodule

// File: doc/decoding.md
# decoding

Single-error-correcting decoder for the 7-bit Hamming-style codewords produced by the team's `encoding` block (data bit 0 transmitted inverted). Accepts one codeword per `active` cycle, recovers the 4 data bits, corrects any single-bit error through a two-stage pipeline, and keeps per-block error statistics. Sits at the receive end of the encoder link, before the data consumer.

## Interface

Parameters:
- `WORDS`, 7, number of codewords in one block; once this many words have been accepted, input is ignored until reset.
- `CNT_W`, 4, width of `err_count`.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset; `reset = 0` clears all state immediately.
- `byte_in`  input  [0:6]  received codeword: `[0]` is inverted d0, `[1:3]` are d1..d3, `[4:6]` are parity p0..p2.
- `active`  input  1  `byte_in` valid this cycle.
- `bits_out`  output  [0:3]  corrected data d0..d3.
- `ready`  output  1  `bits_out` and the flags are valid this cycle; one-cycle pulse per word.
- `err_fixed`  output  1  with `ready`: a data bit (d0..d3) was corrected.
- `par_err`  output  1  with `ready`: a parity bit was in error; data unchanged.
- `err_count`  output  [CNT_W-1:0]  number of words in the current block with nonzero syndrome; saturates at all-ones.
- `done`  output  1  high once `WORDS` words have been accepted; stays high until reset.

## Operation

- Recover raw data: d0 = ~byte_in[0], d1..d3 = byte_in[1..3].
- Syndrome `syn = {s2,s1,s0}`:
  - s0 = byte_in[4] ^ d0 ^ d1 ^ d3
  - s1 = byte_in[5] ^ d0 ^ d2 ^ d3
  - s2 = byte_in[6] ^ d1 ^ d2 ^ d3
- Syndrome decode:
  - 000: no error.
  - 011: flip d0. 101: flip d1. 110: flip d2. 111: flip d3. `err_fixed` = 1.
  - 001, 010, 100: error in p0, p1, p2. `par_err` = 1, data passed unchanged.
- Double errors are not detected. They are miscorrected as a single error, and this is the required behaviour.
- Acceptance: a word is accepted when `active` = 1 and `done` = 0. Each accepted word increments `word_cnt`. `done` is set on the edge that accepts word number `WORDS`.
- `err_count` increments on every accepted word whose syndrome is nonzero. It saturates and does not wrap.
- `active` while `done` = 1: ignored. No `ready` pulse and no counter change.
- Only a reset starts a new block.

## Timing

- Reset values, asynchronous on `reset` = 0: `bits_out` = 0, `ready` = 0, `err_fixed` = 0, `par_err` = 0, `err_count` = 0, `done` = 0. Internal `word_cnt` = 0 and both pipeline valid bits = 0.
- Stage 1 (edge k): register raw data, syndrome and a valid bit for the word accepted at edge k.
- Stage 2 (edge k+1): apply correction and register `bits_out`, flags, `ready` = 1.
- Latency: `active` sampled at edge k gives `ready` high during the cycle after edge k+1.
- Throughput: one word per clock. Back-to-back `active` gives back-to-back `ready`.
- `ready` = 0 in any cycle with no stage-2 word. `bits_out` and the flags hold their last values while `ready` = 0.
- `err_count` and `done` update at stage 1 (edge k). Their observable update therefore leads the matching `ready` by one cycle.
- Last word: the word accepted with `done` rising still propagates normally, giving one final `ready` two edges later.
- Reset asserted mid-pipeline: in-flight words are discarded, and no `ready` pulse appears after reset deasserts.
- Reset deassertion is synchronized externally and needs no handling here.

## Structure

- Shared package `hamming_pkg`:
  - `CODE_W = 7` and `DATA_W = 4`.
  - Syndrome localparams `SYN_D0 = 3'b011`, `SYN_D1 = 3'b101`, `SYN_D2 = 3'b110`, `SYN_D3 = 3'b111`, `SYN_P0 = 3'b001`, `SYN_P1 = 3'b010`, `SYN_P2 = 3'b100`.
  - `typedef logic [0:6] codeword_t` and `typedef logic [0:3] data_t`.
- One sub-module, `hamming_syndrome`: purely combinational, `codeword_t` in, raw `data_t` and 3-bit syndrome out. Reused later by a link-quality monitor.
- Top level contains the two pipeline stages, the correction mux, `word_cnt`, `err_count` and `done`.

## Test plan

- Clean word: `byte_in` = 7'b0011010 (data 1011) with `active` for one cycle → two edges later `ready` = 1, `bits_out` = 4'b1011, both flags 0, `err_count` = 0.
- Data error: `byte_in` = 7'b0001010 (d2 flipped) → `bits_out` = 4'b1011, `err_fixed` = 1, `err_count` = 1. Repeat for each of d0..d3.
- Parity error: `byte_in` = 7'b1000001 (data 0000, p2 flipped) → `bits_out` = 4'b0000, `par_err` = 1, `err_fixed` = 0.
- Block limit: 9 consecutive `active` cycles with `WORDS` = 7 → exactly 7 `ready` pulses, back-to-back; `done` high after the 7th accept; words 8 and 9 ignored.
- Saturation: `CNT_W` = 2, 7 erroneous words → `err_count` stops at 3.
- Reset mid-flight: `reset` low one cycle after an `active` → all outputs 0 immediately; no `ready` afterward; a new block is accepted after reset with `word_cnt` restarted.
